// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, shifted out MSB-first.
// Optional BIT_SERIALIZER_PARITY_EN appends one even-parity bit after each word.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_data,
    output logic             o_valid,
    output logic             o_busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
    logic parity_reg, parity_next;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             accept;

    assign accept = i_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            count_reg  <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            count_reg  <= count_next;
`ifdef BIT_SERIALIZER_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        count_next  = count_reg;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                    shift_next = i_word;
                    count_next = LAST;
`ifdef BIT_SERIALIZER_PARITY_EN
                    parity_next = ^i_word;
`endif
                end
            end
            SHIFT: begin
                if (count_reg != '0) begin
                    shift_next = shift_reg << 1;
                    count_next = count_reg - CW'(1);
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_next = PARITY;
                    shift_next = '0;
`else
                    // Reload on the last-bit cycle keeps the stream gap-free.
                    if (accept) begin
                        shift_next = i_word;
                        count_next = LAST;
                    end else begin
                        state_next = IDLE;
                        shift_next = '0;
                    end
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_next  = SHIFT;
                    shift_next  = i_word;
                    count_next  = LAST;
                    parity_next = ^i_word;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
                shift_next = '0;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        o_ready = 1'b0;
        o_data  = 1'b0;
        o_valid = (state_reg != IDLE);
        o_busy  = (state_reg != IDLE);
        case (state_reg)
            IDLE:  o_ready = 1'b1;
            SHIFT: begin
                o_data = shift_reg[WIDTH-1];
`ifndef BIT_SERIALIZER_PARITY_EN
                o_ready = (count_reg == '0);
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                o_data  = parity_reg;
                o_ready = 1'b1;
            end
`endif
            default: begin
                o_ready = 1'b0;
                o_data  = 1'b0;
            end
        endcase
    end

endmodule
